// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues word-aligned reads to a one-cycle-latency
// instruction memory and presents the returned instruction with its PC.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  input  logic        if_id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] count_q, count_d;
  logic [31:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_count      = count_q;

  // State register and fetch bookkeeping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_BOOT;
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= 32'h0000_0000;
      hold_pc_q   <= 32'h0000_0000;
      hold_inst_q <= 32'h0000_0000;
      count_q     <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
      count_q     <= count_d;
    end
  end

  // Next-state, memory request and presentation logic
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    count_d     = count_q;
    imem_en     = 1'b0;
    if_valid    = 1'b0;
    if_pc       = 32'h0000_0000;
    if_inst     = 32'h0000_0000;

    if (redirect_valid) begin
      imem_addr = redirect_aligned;
    end else begin
      imem_addr = fetch_pc_q;
    end

    if (!rstn) begin
      state_d = ST_BOOT;
    end else if (redirect_valid) begin
      // Redirect wins over stall; any held entry is simply abandoned.
      imem_en = 1'b1;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT: begin
          imem_en = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if_valid = 1'b1;
          if_pc    = resp_pc_q;
          if_inst  = imem_rdata;
          imem_en  = !if_id_stall;
          if (if_id_stall) begin
            // Memory data is gone next cycle, so capture it now.
            hold_pc_d   = resp_pc_q;
            hold_inst_d = imem_rdata;
            state_d     = ST_HOLD;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_HOLD: begin
          if_valid = 1'b1;
          if_pc    = hold_pc_q;
          if_inst  = hold_inst_q;
          imem_en  = !if_id_stall;
          if (if_id_stall) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end

    if (imem_en) begin
      resp_pc_d  = imem_addr;
      fetch_pc_d = imem_addr + 32'd4;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    if (if_valid && !if_id_stall) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a one-cycle-latency memory returning addr>>2.
module tb_if_fetch_unit;

  logic        clk;
  logic        rstn;
  logic [31:0] imem_addr, imem_rdata;
  logic        imem_en;
  logic [31:0] if_pc, if_inst, fetch_count;
  logic        if_valid;
  logic        if_id_stall, redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] imem_addr2, imem_rdata2, if_pc2, if_inst2, fetch_count2, redirect_pc2;
  logic        imem_en2, if_valid2, if_id_stall2, redirect_valid2;

  int checks   = 0;
  int failures = 0;

  if_fetch_unit dut (
    .clk(clk), .rstn(rstn),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
    .if_id_stall(if_id_stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fetch_count(fetch_count)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rstn(rstn),
    .imem_addr(imem_addr2), .imem_en(imem_en2), .imem_rdata(imem_rdata2),
    .if_pc(if_pc2), .if_inst(if_inst2), .if_valid(if_valid2),
    .if_id_stall(if_id_stall2), .redirect_valid(redirect_valid2),
    .redirect_pc(redirect_pc2), .fetch_count(fetch_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: data only after an enabled read, garbage otherwise
  always @(posedge clk) begin
    imem_rdata  <= imem_en  ? (imem_addr  >> 2) : 32'hDEAD_BEEF;
    imem_rdata2 <= imem_en2 ? (imem_addr2 >> 2) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_fetch(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] inst, input logic en,
                           input logic [31:0] addr, input logic [31:0] cnt);
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, ".pc"},    if_pc,   pc);
    chk({tag, ".inst"},  if_inst, inst);
    chk({tag, ".en"},    {31'd0, imem_en}, {31'd0, en});
    chk({tag, ".addr"},  imem_addr, addr);
    chk({tag, ".count"}, fetch_count, cnt);
  endtask

  task automatic next_cycle(input logic st, input logic rv, input logic [31:0] rp);
    @(posedge clk);
    #1;
    if_id_stall    = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    if_id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    if_id_stall2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.en",    {31'd0, imem_en},  32'd0);
    chk("rst.valid", {31'd0, if_valid}, 32'd0);
    chk("rst.pc",    if_pc,   32'd0);
    chk("rst.inst",  if_inst, 32'd0);
    chk("rst.count", fetch_count, 32'd0);

    @(posedge clk); #1; rstn = 1'b1;
    @(negedge clk);
    exp_fetch("boot", 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 32'd0);
    chk("wrap.boot.valid", {31'd0, if_valid2}, 32'd0);

    // Free run: pc 0,4,8,C in cycles 2..5
    for (int k = 2; k <= 5; k++) begin
      next_cycle(1'b0, 1'b0, 32'd0);
      exp_fetch("run", 1'b1, 32'(4 * (k - 2)), 32'(k - 2), 1'b1, 32'(4 * (k - 1)), 32'(k - 2));
      if (k == 2) begin
        chk("wrap.pc0", if_pc2, 32'hFFFF_FFF8); chk("wrap.inst0", if_inst2, 32'h3FFF_FFFE);
      end else if (k == 3) begin
        chk("wrap.pc1", if_pc2, 32'hFFFF_FFFC); chk("wrap.inst1", if_inst2, 32'h3FFF_FFFF);
      end else if (k == 4) begin
        chk("wrap.pc2", if_pc2, 32'h0000_0000); chk("wrap.inst2", if_inst2, 32'h0000_0000);
      end else begin
        chk("wrap.count", fetch_count2, 32'd3);
      end
    end

    // Three stalled cycles on pc 0x10
    for (int s = 0; s < 3; s++) begin
      next_cycle(1'b1, 1'b0, 32'd0);
      exp_fetch("stall", 1'b1, 32'h10, 32'd4, 1'b0, 32'h14, 32'd4);
    end
    next_cycle(1'b0, 1'b0, 32'd0);
    exp_fetch("release", 1'b1, 32'h10, 32'd4, 1'b1, 32'h14, 32'd4);
    next_cycle(1'b0, 1'b0, 32'd0);
    exp_fetch("after_hold", 1'b1, 32'h14, 32'd5, 1'b1, 32'h18, 32'd5);

    // Redirect from RUN
    next_cycle(1'b0, 1'b1, 32'h200);
    exp_fetch("redir_run", 1'b0, 32'd0, 32'd0, 1'b1, 32'h200, 32'd6);
    next_cycle(1'b0, 1'b0, 32'd0);
    exp_fetch("tgt0", 1'b1, 32'h200, 32'h80, 1'b1, 32'h204, 32'd6);
    next_cycle(1'b0, 1'b0, 32'd0);
    exp_fetch("tgt1", 1'b1, 32'h204, 32'h81, 1'b1, 32'h208, 32'd7);

    // Redirect while holding, misaligned target
    next_cycle(1'b1, 1'b0, 32'd0);
    exp_fetch("hold_in", 1'b1, 32'h208, 32'h82, 1'b0, 32'h20C, 32'd8);
    next_cycle(1'b1, 1'b1, 32'h403);
    exp_fetch("redir_hold", 1'b0, 32'd0, 32'd0, 1'b1, 32'h400, 32'd8);
    next_cycle(1'b0, 1'b0, 32'd0);
    exp_fetch("tgt400", 1'b1, 32'h400, 32'h100, 1'b1, 32'h404, 32'd8);
    next_cycle(1'b0, 1'b0, 32'd0);
    exp_fetch("tgt404", 1'b1, 32'h404, 32'h101, 1'b1, 32'h408, 32'd9);

    // Reach a stall at pc 0x30, then reset in the middle of it
    next_cycle(1'b0, 1'b1, 32'h30);
    exp_fetch("redir30", 1'b0, 32'd0, 32'd0, 1'b1, 32'h30, 32'd10);
    next_cycle(1'b1, 1'b0, 32'd0);
    exp_fetch("stall30", 1'b1, 32'h30, 32'hC, 1'b0, 32'h34, 32'd10);
    next_cycle(1'b1, 1'b0, 32'd0);
    exp_fetch("hold30", 1'b1, 32'h30, 32'hC, 1'b0, 32'h34, 32'd10);

    #2; rstn = 1'b0;
    #1;
    exp_fetch("midrst", 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h500;
    #1;
    chk("rst_redir.en",    {31'd0, imem_en},  32'd0);
    chk("rst_redir.valid", {31'd0, if_valid}, 32'd0);
    redirect_valid = 1'b0; redirect_pc = 32'd0;

    @(posedge clk); #1; rstn = 1'b1; if_id_stall = 1'b0;
    @(negedge clk);
    exp_fetch("reboot", 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 32'd0);
    next_cycle(1'b0, 1'b0, 32'd0);
    exp_fetch("rerun0", 1'b1, 32'd0, 32'd0, 1'b1, 32'd4, 32'd0);
    next_cycle(1'b0, 1'b0, 32'd0);
    exp_fetch("rerun1", 1'b1, 32'd4, 32'd1, 1'b1, 32'd8, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
